axi4_xfer_sched: RTL and testbench

AXI4_XFER_SCHED -- requirements
Module: axi4_xfer_sched

---
 rtl/axi4_sched_pkg.sv | 25 ++
 rtl/axi4_sched_rr2.sv | 29 ++
 rtl/axi4_xfer_sched.sv | 212 +++++++++++++++++++++
 tb/tb_axi4_xfer_sched.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/axi4_sched_pkg.sv
// Shared types and constants for the AXI4 transfer scheduler.
package axi4_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_ERROR   = 3'd5
  } sched_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RESP    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_UNEXP   = 2'd3
  } sched_err_e;

  function automatic int unsigned burst_bytes(input int unsigned beats,
                                              input int unsigned xsize);
    return beats * xsize;
  endfunction

endpackage

// File: rtl/axi4_sched_rr2.sv
// Two-way round-robin arbiter; the last-grant register only moves on accept.
module axi4_sched_rr2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // 1 = read was granted last, so write wins a tie
  logic last_rd_q, last_rd_d;

  always_comb begin
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_rd_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    last_rd_d = last_rd_q;
    if (accept_i && (gnt_o != 2'b00)) last_rd_d = gnt_o[1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_rd_q <= 1'b1;
    else       last_rd_q <= last_rd_d;
  end

endmodule

// File: rtl/axi4_xfer_sched.sv
// Schedules fixed-size AXI4 write/read bursts over circular buffer regions,
// with response watchdog and sticky error reporting.
module axi4_xfer_sched
  import axi4_sched_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH   = 32,
  parameter int unsigned AXI_XSIZE        = 8,
  parameter int unsigned DATA_COUNT_WIDTH = 10,
  parameter int unsigned BURST_BEATS      = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic                        clear_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   wr_base_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   rd_base_i,
  input  logic [15:0]                 buf_bursts_i,
  input  logic [DATA_COUNT_WIDTH-1:0] wr_data_count_i,
  input  logic [DATA_COUNT_WIDTH-1:0] rd_space_i,
  output logic [1:0]                  mgr_req_o,
  input  logic [1:0]                  mgr_rsp_i,
  input  logic [1:0]                  mgr_wr_err_i,
  input  logic [1:0]                  mgr_rd_err_i,
  output logic [AXI_ADDR_WIDTH-1:0]   mgr_wr_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0]   mgr_rd_addr_o,
  output logic                        busy_o,
  output logic                        err_o,
  output logic [1:0]                  err_code_o,
  output logic [31:0]                 wr_cnt_o,
  output logic [31:0]                 rd_cnt_o
);

  localparam int unsigned BB = burst_bytes(BURST_BEATS, AXI_XSIZE);
  localparam logic [AXI_ADDR_WIDTH-1:0]   BB_A    = AXI_ADDR_WIDTH'(BB);
  localparam logic [DATA_COUNT_WIDTH-1:0] BEATS_C = DATA_COUNT_WIDTH'(BURST_BEATS);
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  sched_state_e              state_q, state_d;
  sched_err_e                code_q, code_d;
  logic [1:0]                req_q, req_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;
  logic                      ign_q, ign_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic [AXI_ADDR_WIDTH-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [31:0]               wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  logic [15:0]               bufs_eff;
  logic [AXI_ADDR_WIDTH-1:0] region_len, wr_off_nxt, rd_off_nxt;
  logic [1:0]                elig, gnt, rsp_v;
  logic                      accept;

  assign elig[0] = enable_i && (wr_data_count_i >= BEATS_C);
  assign elig[1] = enable_i && (rd_space_i >= BEATS_C);
  // A response left over from a transfer abandoned by reset is dropped once.
  assign rsp_v   = ign_q ? 2'b00 : mgr_rsp_i;

  axi4_sched_rr2 u_rr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (elig),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  always_comb begin
    bufs_eff   = (buf_bursts_i == 16'd0) ? 16'd1 : buf_bursts_i;
    region_len = AXI_ADDR_WIDTH'(bufs_eff) * BB_A;
    wr_off_nxt = wr_off_q + BB_A;
    if (wr_off_nxt >= region_len) wr_off_nxt = '0;
    rd_off_nxt = rd_off_q + BB_A;
    if (rd_off_nxt >= region_len) rd_off_nxt = '0;
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    wd_d      = '0;
    wr_off_d  = wr_off_q;
    rd_off_d  = rd_off_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    accept    = 1'b0;
    ign_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rsp_v != 2'b00) begin
          state_d = S_ERROR;
          code_d  = ERR_UNEXP;
        end else if (gnt[0]) begin
          accept    = 1'b1;
          state_d   = S_WR_REQ;
          wr_addr_d = wr_base_i + wr_off_q;
        end else if (gnt[1]) begin
          accept    = 1'b1;
          state_d   = S_RD_REQ;
          rd_addr_d = rd_base_i + rd_off_q;
        end
      end
      S_WR_REQ, S_RD_REQ: begin
        if (rsp_v != 2'b00) begin
          state_d = S_ERROR;
          code_d  = ERR_UNEXP;
        end else begin
          state_d = (state_q == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (rsp_v == 2'b01) begin
          if (mgr_wr_err_i != 2'b00) begin
            state_d = S_ERROR;
            code_d  = ERR_RESP;
          end else begin
            wr_off_d = wr_off_nxt;
            wr_cnt_d = wr_cnt_q + 32'd1;
            state_d  = S_IDLE;
          end
        end else if (rsp_v != 2'b00) begin
          state_d = S_ERROR;
          code_d  = ERR_UNEXP;
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERROR;
          code_d  = ERR_TIMEOUT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (rsp_v == 2'b10) begin
          if (mgr_rd_err_i != 2'b00) begin
            state_d = S_ERROR;
            code_d  = ERR_RESP;
          end else begin
            rd_off_d = rd_off_nxt;
            rd_cnt_d = rd_cnt_q + 32'd1;
            state_d  = S_IDLE;
          end
        end else if (rsp_v != 2'b00) begin
          state_d = S_ERROR;
          code_d  = ERR_UNEXP;
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERROR;
          code_d  = ERR_TIMEOUT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_ERROR: begin
        if (clear_i) begin
          state_d = S_IDLE;
          code_d  = ERR_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        code_d  = ERR_NONE;
      end
    endcase
    // Outputs are registered views of the next state.
    req_d  = {state_d == S_RD_REQ, state_d == S_WR_REQ};
    busy_d = (state_d == S_WR_REQ) || (state_d == S_WR_WAIT) ||
             (state_d == S_RD_REQ) || (state_d == S_RD_WAIT);
    err_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      code_q    <= ERR_NONE;
      req_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      ign_q     <= 1'b1;
      wd_q      <= '0;
      wr_off_q  <= '0;
      rd_off_q  <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      ign_q     <= ign_d;
      wd_q      <= wd_d;
      wr_off_q  <= wr_off_d;
      rd_off_q  <= rd_off_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  assign mgr_req_o     = req_q;
  assign mgr_wr_addr_o = wr_addr_q;
  assign mgr_rd_addr_o = rd_addr_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign err_code_o    = code_q;
  assign wr_cnt_o      = wr_cnt_q;
  assign rd_cnt_o      = rd_cnt_q;

endmodule

// File: tb/tb_axi4_xfer_sched.sv
// Directed bench for axi4_xfer_sched with hand-computed expectations.
module tb_axi4_xfer_sched;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] wr_base_i = 32'h5000;
  logic [31:0] rd_base_i = 32'h6000;
  logic [15:0] buf_bursts_i = 16'd8;
  logic [9:0]  wr_data_count_i = '0;
  logic [9:0]  rd_space_i = '0;
  logic [1:0]  mgr_req_o;
  logic [1:0]  mgr_rsp_i = '0;
  logic [1:0]  mgr_wr_err_i = '0;
  logic [1:0]  mgr_rd_err_i = '0;
  logic [31:0] mgr_wr_addr_o, mgr_rd_addr_o;
  logic        busy_o, err_o;
  logic [1:0]  err_code_o;
  logic [31:0] wr_cnt_o, rd_cnt_o;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  axi4_xfer_sched #(
    .AXI_ADDR_WIDTH   (32),
    .AXI_XSIZE        (8),
    .DATA_COUNT_WIDTH (10),
    .BURST_BEATS      (4),
    .TIMEOUT_CYCLES   (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .clear_i         (clear_i),
    .wr_base_i       (wr_base_i),
    .rd_base_i       (rd_base_i),
    .buf_bursts_i    (buf_bursts_i),
    .wr_data_count_i (wr_data_count_i),
    .rd_space_i      (rd_space_i),
    .mgr_req_o       (mgr_req_o),
    .mgr_rsp_i       (mgr_rsp_i),
    .mgr_wr_err_i    (mgr_wr_err_i),
    .mgr_rd_err_i    (mgr_rd_err_i),
    .mgr_wr_addr_o   (mgr_wr_addr_o),
    .mgr_rd_addr_o   (mgr_rd_addr_o),
    .busy_o          (busy_o),
    .err_o           (err_o),
    .err_code_o      (err_code_o),
    .wr_cnt_o        (wr_cnt_o),
    .rd_cnt_o        (rd_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Waits (bounded) for a request pulse, checks it, then steps into WAIT.
  task automatic expect_req(input string tag, input logic [1:0] exp_req, input logic [31:0] exp_addr);
    int unsigned n = 0;
    while (mgr_req_o == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, mgr_req_o, exp_req);
    if (exp_req == 2'b01) check({tag, "_waddr"}, mgr_wr_addr_o, exp_addr);
    else                  check({tag, "_raddr"}, mgr_rd_addr_o, exp_addr);
    tick();
    check({tag, "_pulse"}, {busy_o, mgr_req_o}, 3'b100);
  endtask

  task automatic respond(input logic [1:0] rsp, input logic [1:0] werr, input logic [1:0] rerr);
    mgr_rsp_i    = rsp;
    mgr_wr_err_i = werr;
    mgr_rd_err_i = rerr;
    tick();
    mgr_rsp_i    = '0;
    mgr_wr_err_i = '0;
    mgr_rd_err_i = '0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear", {err_o, err_code_o}, 3'b000);
  endtask

  initial begin
    logic bad;
    tick();
    tick();
    check("rst_outs", {mgr_req_o, busy_o, err_o, err_code_o}, 6'd0);
    check("rst_cnts", {wr_cnt_o, rd_cnt_o}, 64'd0);

    enable_i        = 1'b1;
    wr_data_count_i = 10'd4;
    rst_i           = 1'b0;

    // single write, then the next one advances by one burst
    expect_req("w0", 2'b01, 32'h5000);
    respond(2'b01, 2'b00, 2'b00);
    check("w0_cnt", wr_cnt_o, 32'd1);
    expect_req("w1", 2'b01, 32'h5020);
    rd_space_i = 10'd4;
    respond(2'b01, 2'b00, 2'b00);
    check("w1_cnt", wr_cnt_o, 32'd2);

    // both eligible: alternate starting with read
    expect_req("r0", 2'b10, 32'h6000);
    respond(2'b10, 2'b00, 2'b00);
    expect_req("w2", 2'b01, 32'h5040);
    respond(2'b01, 2'b00, 2'b00);
    expect_req("r1", 2'b10, 32'h6020);
    enable_i = 1'b0;
    respond(2'b10, 2'b00, 2'b00);
    check("alt_cnts", {wr_cnt_o, rd_cnt_o}, {32'd3, 32'd2});
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bad |= (mgr_req_o != 2'b00) || busy_o;
    end
    check("disabled_idle", bad, 1'b0);

    // reset in the middle of a write wait, with a late response afterwards
    buf_bursts_i = 16'd2;
    rd_space_i   = 10'd0;
    enable_i     = 1'b1;
    expect_req("w3", 2'b01, 32'h5060);
    rst_i = 1'b1;
    #1;
    check("midrst_outs", {mgr_req_o, busy_o, err_o, err_code_o}, 6'd0);
    check("midrst_cnts", {wr_cnt_o, rd_cnt_o}, 64'd0);
    tick();
    rst_i     = 1'b0;
    mgr_rsp_i = 2'b01;
    tick();
    mgr_rsp_i = 2'b00;
    check("late_rsp_ignored", {err_o, err_code_o}, 3'b000);

    // two-burst region wraps
    expect_req("b0", 2'b01, 32'h5000);
    respond(2'b01, 2'b00, 2'b00);
    expect_req("b1", 2'b01, 32'h5020);
    respond(2'b01, 2'b00, 2'b00);
    expect_req("b2", 2'b01, 32'h5000);

    // AXI error response
    respond(2'b01, 2'b10, 2'b00);
    check("axi_err", {err_o, err_code_o}, 3'b101);
    check("axi_err_cnt", wr_cnt_o, 32'd2);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bad |= (mgr_req_o != 2'b00) || busy_o || !err_o;
    end
    check("err_hold", bad, 1'b0);
    do_clear();
    expect_req("retry", 2'b01, 32'h5000);
    respond(2'b01, 2'b00, 2'b00);
    check("retry_cnt", wr_cnt_o, 32'd3);

    // watchdog: code 2 exactly 16 cycles after WAIT entry
    expect_req("to", 2'b01, 32'h5020);
    bad = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      bad |= err_o;
    end
    check("to_early", bad, 1'b0);
    tick();
    check("to_code", {err_o, err_code_o}, 3'b110);
    do_clear();

    // read response while waiting on a write
    expect_req("ux", 2'b01, 32'h5020);
    respond(2'b10, 2'b00, 2'b00);
    check("ux_wait", {err_o, err_code_o}, 3'b111);
    enable_i = 1'b0;
    do_clear();

    // response arriving in IDLE
    respond(2'b01, 2'b00, 2'b00);
    check("ux_idle", {err_o, err_code_o}, 3'b111);
    do_clear();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
